// File: rtl/pwm_defs.sv
// rtl/pwm_defs.sv - shared register map, bit indices and FSM encoding for pwm_capture
// Purpose: constants shared by the capture top and anything decoding its registers.
// Contents: byte addresses of CTRL/STATUS/RESULT, CTRL and STATUS bit positions,
//           2-bit measurement FSM state encoding.
package pwm_defs;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_RESULT = 8'h08;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int ST_VALID = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_MISS  = 3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_HIGH      = 2'd2,
        S_LOW       = 2'd3
    } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - synchronizer plus single-cycle rise/fall edge detector
// Purpose: bring an asynchronous level into the clk domain and flag its edges.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   async_i  in   asynchronous input level
//   rise_o   out  one-cycle pulse on a synchronized 0->1 transition
//   fall_o   out  one-cycle pulse on a synchronized 1->0 transition
module pwm_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;
    logic              lvl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    // Fixed depth from async_i to the edge pulses keeps measured intervals exact.
    assign lvl    = sync_q[STAGES-1];
    assign rise_o = lvl & ~dly_q;
    assign fall_o = ~lvl & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with register interface
// Purpose: measure period and high time of pwm_in and report them as RESULT.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   addr, wdata        register byte address and write data
//   wen, ren           one-cycle write / read strobes
//   rdata              registered read data, valid the cycle after ren
//   pwm_in             asynchronous PWM input
//   irq                registered level interrupt
module pwm_capture
    import pwm_defs::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        wen,
    input  logic        ren,
    input  logic        pwm_in,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] res_per_q, res_high_q;
    logic             en_q, irq_en_q;
    logic             valid_q, ovf_q, miss_q, irq_q;
    logic [31:0]      rdata_q, rd_mux;
    logic             rise, fall, sat, latch;
    logic             wr_ctrl, wr_status;
    logic             unused_wdata;

    pwm_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (pwm_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // A rise in LOW ends the period by latching, so only a counting step can saturate.
    assign sat = en_q & (per_cnt_q == CNT_MAX) &
                 ((state_q == S_HIGH) | ((state_q == S_LOW) & ~rise));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:      state_d = S_WAIT_RISE;
                S_WAIT_RISE: if (rise) state_d = S_HIGH;
                S_HIGH:      if (sat) state_d = S_WAIT_RISE;
                             else if (fall) state_d = S_LOW;
                S_LOW:       if (rise) state_d = S_HIGH;
                             else if (sat) state_d = S_WAIT_RISE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        per_cnt_d  = per_cnt_q;
        high_cnt_d = high_cnt_q;
        latch      = 1'b0;
        if (!en_q || sat) begin
            per_cnt_d  = '0;
            high_cnt_d = '0;
        end else begin
            case (state_q)
                S_WAIT_RISE: begin
                    if (rise) begin
                        per_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    // The fall cycle still belongs to the period but not to the high time.
                    per_cnt_d = per_cnt_q + CNT_ONE;
                    if (!fall) high_cnt_d = high_cnt_q + CNT_ONE;
                end
                S_LOW: begin
                    if (rise) begin
                        latch      = 1'b1;
                        per_cnt_d  = CNT_ONE;
                        high_cnt_d = CNT_ONE;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    per_cnt_d  = '0;
                    high_cnt_d = '0;
                end
            endcase
        end
    end

    assign wr_ctrl   = wen & (addr == ADDR_CTRL);
    assign wr_status = wen & (addr == ADDR_STATUS);

    always_comb begin
        rd_mux = 32'h0;
        case (addr)
            ADDR_CTRL:   rd_mux = {30'h0, irq_en_q, en_q};
            ADDR_STATUS: rd_mux = {28'h0, miss_q, (state_q != S_IDLE), ovf_q, valid_q};
            ADDR_RESULT: rd_mux = {16'(res_per_q), 16'(res_high_q)};
            default:     rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            res_per_q  <= '0;
            res_high_q <= '0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            miss_q     <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            if (latch) begin
                res_per_q  <= per_cnt_q;
                res_high_q <= high_cnt_q;
            end
            if (wr_ctrl) begin
                en_q     <= wdata[CTRL_EN];
                irq_en_q <= wdata[CTRL_IRQ_EN];
            end
            // Hardware set is ORed after the W1C mask so it wins a same-cycle collision.
            valid_q <= latch | (valid_q & ~(wr_status & wdata[ST_VALID]));
            ovf_q   <= sat | (ovf_q & ~(wr_status & wdata[ST_OVF]));
            miss_q  <= (latch & valid_q) | (miss_q & ~(wr_status & wdata[ST_MISS]));
            irq_q   <= irq_en_q & (valid_q | ovf_q | miss_q);
            if (ren) rdata_q <= rd_mux;
        end
    end

    assign unused_wdata = ^{wdata[31:4], wdata[ST_BUSY]};
    assign rdata        = rdata_q;
    assign irq          = irq_q;

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an external PWM waveform and reports its period and high time on the team's simple register bus (addr/wdata/rdata/wen/ren). It is the receive-side counterpart of the PWM generator. RESULT is packed as {period[31:16], high[15:0]}, the same layout as the generator's CTRL word, so a generator→capture loopback reads back exactly the word that was written. Intended uses are loopback self-test and capture of external PWM sources.

Parameters:
CNT_W, 16, width of the period/high counters (max 16, because of the RESULT packing)
SYNC_STAGES, 2, number of flops in the pwm_in synchronizer (min 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
addr  in  8  register byte address
wdata  in  32  write data
rdata  out  32  read data, registered
wen  in  1  write strobe, one cycle
ren  in  1  read strobe, one cycle
pwm_in  in  1  asynchronous PWM input
irq  out  1  interrupt, level, registered

Behaviour:
- Reset (async assert, sync release): all flops go to 0, FSM goes to IDLE; rdata=0, irq=0, RESULT=0, STATUS=0.
- Register map (32-bit, byte addresses):
  - 0x00 CTRL, RW: [0] en, [1] irq_en; other bits read 0.
  - 0x04 STATUS: [0] valid (W1C), [1] overflow (W1C), [2] busy (RO, FSM != IDLE), [3] miss (W1C).
  - 0x08 RESULT, RO: {period, high}, each zero-extended to 16 bits.
  - Writes to RO bits or unmapped addresses are ignored.
- Bus timing:
  - Write: takes effect at the posedge where wen=1.
  - Read: rdata <= selected register at the posedge where ren=1, so it is valid one cycle after ren. rdata holds its value while ren=0. Unmapped reads return 0.
  - wen and ren in the same cycle: both act; rdata shows the pre-write value.
- Input path: pwm_in → SYNC_STAGES flops → one delay flop. rise = s & ~s_d, fall = ~s & s_d. The input→edge latency is fixed, so the counts are exact.
- FSM:
  - IDLE: counters held at 0. en=1 → WAIT_RISE.
  - WAIT_RISE: on rise → HIGH, per_cnt=1, high_cnt=1. No latch on this first rise.
  - HIGH: per_cnt++ and high_cnt++ each cycle. On fall → LOW (high_cnt frozen).
  - LOW: per_cnt++ each cycle. On rise: latch RESULT={per_cnt, high_cnt}, set valid, reload both counters to 1, → HIGH.
  - Any state with en=0: → IDLE next cycle, counters cleared, RESULT retained.
- Measurement definitions:
  - period = clk cycles between consecutive synchronized rises.
  - high = clk cycles from a rise to the following fall.
- Saturation: if per_cnt would exceed 2^CNT_W-1, set overflow, discard the measurement (no latch, valid unchanged), → WAIT_RISE. This covers 0% and 100% duty (no edges), which never produce valid.
- Miss: a latch while valid=1 sets miss; RESULT is overwritten with the newest value.
- Set/clear collisions: if a hardware set and a W1C clear of the same bit land in the same cycle, the set wins.
- irq <= irq_en & (valid | overflow | miss), registered (one cycle after the flag).
- Reset mid-measurement: flags and RESULT clear immediately (async). The first result after release needs two rises.

Decomposition:
- Shared defines/package pwm_defs:
  - address constants ADDR_CTRL=0x00, ADDR_STATUS=0x04, ADDR_RESULT=0x08
  - STATUS/CTRL bit indices
  - FSM state encodings (IDLE, WAIT_RISE, HIGH, LOW), 2-bit
- One sub-module, pwm_edge_sync: parameterised synchronizer plus edge detector, outputs rise/fall pulses. It is reusable for other async inputs.
- Top module: register file, FSM, counters, irq.

Test Plan:
1. Write CTRL=0x1; drive pwm_in with period 100 and high 30 → after the 2nd rise, STATUS[0]=1, STATUS[2]=1, RESULT read = 0x0064001E.
2. Write STATUS=0x1 → valid reads 0. The next period sets valid again with RESULT unchanged (0x0064001E). With irq_en=1, irq tracks valid one cycle later.
3. Change the waveform to period 50 / high 10 and do not clear over 3 periods → STATUS[3]=1, RESULT = 0x0032000A.
4. CNT_W=8: hold pwm_in high for 300 cycles after a rise → STATUS[1]=1, valid stays 0; with irq_en=1, irq=1. Write STATUS=0x2 → overflow clears and irq drops.
5. Clear en during HIGH → busy=0 within 2 cycles and RESULT retained. Re-enable → no valid until two fresh rises, then the correct value.
6. Assert reset_n low mid-period → rdata, irq and STATUS go to 0 without a clock edge. After release, an unmapped read (0x0C) returns 0.
